// File: rtl/baudrate_gen_comp.sv
// -----------------------------------------------------------------------------
// baudrate_gen_comp
// Fractional baud-rate generator with per-byte compensation.
//
// Each bit is built from U "up" periods of N+1 clocks and D "down" periods of
// N clocks. The periods are interleaved to spread the error. Once per byte
// frame, the last period of the final bit is stretched by C clocks.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   Enable_i     run (1) / idle (0)
//   Sync_i       one-cycle frame restart strobe (start-bit alignment)
//   AcqPeriod_i  N, base period in clocks
//   UpCount_i    U, number of N+1-clock periods per bit
//   DownCount_i  D, number of N-clock periods per bit
//   ByteComp_i   C, extra clocks added once per byte frame
//   AcqSig_o     pulse at the end of every period
//   BaudSig_o    pulse at the end of every bit
//   ByteSig_o    pulse at the end of every byte frame
//   BitIdx_o     index of the bit in progress
//   Busy_o       high while running
//
// Configuration is taken into a shadow copy only at frame boundaries (start,
// byte end and sync). Input changes in the middle of a byte therefore cannot
// corrupt the timing of that byte.
// -----------------------------------------------------------------------------
module baudrate_gen_comp #(
    parameter int PERIOD_W  = 16,
    parameter int CNT_W     = 4,
    parameter int BYTE_BITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Enable_i,
    input  logic                Sync_i,
    input  logic [PERIOD_W-1:0] AcqPeriod_i,
    input  logic [CNT_W-1:0]    UpCount_i,
    input  logic [CNT_W-1:0]    DownCount_i,
    input  logic [CNT_W-1:0]    ByteComp_i,
    output logic                AcqSig_o,
    output logic                BaudSig_o,
    output logic                ByteSig_o,
    output logic [3:0]          BitIdx_o,
    output logic                Busy_o
);

    // N+1 is computed one bit wider so that it never wraps. One more bit of
    // headroom absorbs the byte compensation.
    localparam int BASE_W = PERIOD_W + 1;
    localparam int LEN_W  = ((BASE_W > CNT_W) ? BASE_W : CNT_W) + 1;

    localparam logic [3:0]          LAST_BIT = 4'(BYTE_BITS - 1);
    localparam logic [PERIOD_W-1:0] N_MIN    = PERIOD_W'(32'd2);
    localparam logic [PERIOD_W-1:0] N_RST    = PERIOD_W'(32'd20);
    localparam logic [CNT_W-1:0]    CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(32'd1);
    localparam logic [LEN_W-1:0]    LEN_ZERO = LEN_W'(32'd0);
    localparam logic [LEN_W-1:0]    LEN_ONE  = LEN_W'(32'd1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q;
    logic [PERIOD_W-1:0] n_q;
    logic [CNT_W-1:0]    u_cfg_q;
    logic [CNT_W-1:0]    d_cfg_q;
    logic [CNT_W-1:0]    c_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    u_rem_q;   // up periods still to come after the current one
    logic [CNT_W-1:0]    d_rem_q;   // down periods still to come after the current one
    logic                up_q;      // current period is an up (N+1) period
    logic [3:0]          bit_q;
    logic                acq_q;
    logic                baud_q;
    logic                byte_q;
    logic                busy_q;

    logic [PERIOD_W-1:0] ld_n_d;
    logic [CNT_W-1:0]    ld_u_d;
    logic [CNT_W-1:0]    ld_d_d;
    logic [CNT_W-1:0]    ld_c_d;
    logic [BASE_W-1:0]   base_len_s;
    logic [LEN_W-1:0]    len_s;
    logic                last_period_s;
    logic                last_bit_s;
    logic                period_end_s;
    logic                byte_end_s;
    logic                reload_s;
    logic [CNT_W-1:0]    src_u_s;
    logic [CNT_W-1:0]    src_d_s;
    logic                first_up_d;
    logic [CNT_W-1:0]    first_u_d;
    logic [CNT_W-1:0]    first_d_d;
    logic                next_up_d;
    logic [CNT_W-1:0]    next_u_d;
    logic [CNT_W-1:0]    next_d_d;
    logic [3:0]          bit_next_d;

    // Period ordering: prefer whichever kind has more remaining. Ties go to
    // down periods, and each kind is forced once the other is exhausted.
    function automatic logic pick_up(input logic [CNT_W-1:0] u, input logic [CNT_W-1:0] d);
        logic r;
        if (d == CNT_ZERO) begin
            r = 1'b1;
        end else if (u == CNT_ZERO) begin
            r = 1'b0;
        end else begin
            r = (u > d);
        end
        return r;
    endfunction

    // Clamped shadow candidates, period length and next-period selection.
    always_comb begin
        ld_n_d = AcqPeriod_i;
        ld_u_d = UpCount_i;
        ld_d_d = DownCount_i;
        ld_c_d = ByteComp_i;
        if (AcqPeriod_i < N_MIN) begin
            ld_n_d = N_MIN;
        end else begin
            ld_n_d = AcqPeriod_i;
        end
        // A bit with no periods at all would never end; force one down period.
        if ((UpCount_i == CNT_ZERO) && (DownCount_i == CNT_ZERO)) begin
            ld_d_d = CNT_ONE;
        end else begin
            ld_d_d = DownCount_i;
        end

        last_period_s = (u_rem_q == CNT_ZERO) && (d_rem_q == CNT_ZERO);
        last_bit_s    = (bit_q == LAST_BIT);

        if (up_q) begin
            base_len_s = {1'b0, n_q} + BASE_W'(32'd1);
        end else begin
            base_len_s = {1'b0, n_q};
        end
        if (last_period_s && last_bit_s) begin
            len_s = LEN_W'(base_len_s) + LEN_W'(c_q);
        end else begin
            len_s = LEN_W'(base_len_s) + LEN_ZERO;
        end

        period_end_s = (cnt_q == (len_s - LEN_ONE));
        byte_end_s   = period_end_s && last_period_s && last_bit_s;

        // Shadow reload points: leaving IDLE, byte end, or sync while running.
        if (state_q == ST_IDLE) begin
            reload_s = Enable_i;
        end else begin
            reload_s = Enable_i && (Sync_i || byte_end_s);
        end

        if (reload_s) begin
            src_u_s = ld_u_d;
            src_d_s = ld_d_d;
        end else begin
            src_u_s = u_cfg_q;
            src_d_s = d_cfg_q;
        end

        // First period of a new bit.
        first_up_d = pick_up(src_u_s, src_d_s);
        if (first_up_d) begin
            first_u_d = src_u_s - CNT_ONE;
            first_d_d = src_d_s;
        end else begin
            first_u_d = src_u_s;
            first_d_d = src_d_s - CNT_ONE;
        end

        // Following period within the same bit.
        next_up_d = pick_up(u_rem_q, d_rem_q);
        if (next_up_d) begin
            next_u_d = u_rem_q - CNT_ONE;
            next_d_d = d_rem_q;
        end else begin
            next_u_d = u_rem_q;
            next_d_d = d_rem_q - CNT_ONE;
        end

        // The visible bit index advances the cycle after the bit-end pulse.
        if (baud_q) begin
            if (bit_q == LAST_BIT) begin
                bit_next_d = 4'd0;
            end else begin
                bit_next_d = bit_q + 4'd1;
            end
        end else begin
            bit_next_d = bit_q;
        end
    end

    // Control FSM, counters, shadow configuration and registered pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            n_q     <= N_RST;
            u_cfg_q <= CNT_ZERO;
            d_cfg_q <= CNT_ONE;
            c_q     <= CNT_ZERO;
            cnt_q   <= LEN_ZERO;
            u_rem_q <= CNT_ZERO;
            d_rem_q <= CNT_ZERO;
            up_q    <= 1'b0;
            bit_q   <= 4'd0;
            acq_q   <= 1'b0;
            baud_q  <= 1'b0;
            byte_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    acq_q  <= 1'b0;
                    baud_q <= 1'b0;
                    byte_q <= 1'b0;
                    cnt_q  <= LEN_ZERO;
                    bit_q  <= 4'd0;
                    if (Enable_i) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        n_q     <= ld_n_d;
                        u_cfg_q <= ld_u_d;
                        d_cfg_q <= ld_d_d;
                        c_q     <= ld_c_d;
                        up_q    <= first_up_d;
                        u_rem_q <= first_u_d;
                        d_rem_q <= first_d_d;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        u_rem_q <= CNT_ZERO;
                        d_rem_q <= CNT_ZERO;
                        up_q    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!Enable_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        acq_q   <= 1'b0;
                        baud_q  <= 1'b0;
                        byte_q  <= 1'b0;
                        cnt_q   <= LEN_ZERO;
                        bit_q   <= 4'd0;
                        u_rem_q <= CNT_ZERO;
                        d_rem_q <= CNT_ZERO;
                        up_q    <= 1'b0;
                    end else if (Sync_i) begin
                        // Restart the frame; any pulse due this cycle is dropped.
                        n_q     <= ld_n_d;
                        u_cfg_q <= ld_u_d;
                        d_cfg_q <= ld_d_d;
                        c_q     <= ld_c_d;
                        acq_q   <= 1'b0;
                        baud_q  <= 1'b0;
                        byte_q  <= 1'b0;
                        cnt_q   <= LEN_ZERO;
                        bit_q   <= 4'd0;
                        up_q    <= first_up_d;
                        u_rem_q <= first_u_d;
                        d_rem_q <= first_d_d;
                    end else if (period_end_s) begin
                        acq_q  <= 1'b1;
                        baud_q <= last_period_s;
                        byte_q <= byte_end_s;
                        cnt_q  <= LEN_ZERO;
                        bit_q  <= bit_next_d;
                        if (byte_end_s) begin
                            n_q     <= ld_n_d;
                            u_cfg_q <= ld_u_d;
                            d_cfg_q <= ld_d_d;
                            c_q     <= ld_c_d;
                        end else begin
                            n_q     <= n_q;
                            u_cfg_q <= u_cfg_q;
                            d_cfg_q <= d_cfg_q;
                            c_q     <= c_q;
                        end
                        if (last_period_s) begin
                            up_q    <= first_up_d;
                            u_rem_q <= first_u_d;
                            d_rem_q <= first_d_d;
                        end else begin
                            up_q    <= next_up_d;
                            u_rem_q <= next_u_d;
                            d_rem_q <= next_d_d;
                        end
                    end else begin
                        acq_q  <= 1'b0;
                        baud_q <= 1'b0;
                        byte_q <= 1'b0;
                        cnt_q  <= cnt_q + LEN_ONE;
                        bit_q  <= bit_next_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    acq_q   <= 1'b0;
                    baud_q  <= 1'b0;
                    byte_q  <= 1'b0;
                    cnt_q   <= LEN_ZERO;
                    bit_q   <= 4'd0;
                end
            endcase
        end
    end

    assign AcqSig_o  = acq_q;
    assign BaudSig_o = baud_q;
    assign ByteSig_o = byte_q;
    assign BitIdx_o  = bit_q;
    assign Busy_o    = busy_q;

endmodule

// File: tb/tb_baudrate_gen_comp.sv
// -----------------------------------------------------------------------------
// Directed testbench for baudrate_gen_comp (default parameters).
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge. j counts falling edges after the clock edge that enters RUN, and
// Busy_o is first seen high at j=0. A period of L clocks therefore ends with
// AcqSig_o seen at j=L.
// -----------------------------------------------------------------------------
module tb_baudrate_gen_comp;

    logic        clk = 1'b0;
    logic        rst;
    logic        Enable_i;
    logic        Sync_i;
    logic [15:0] AcqPeriod_i;
    logic [3:0]  UpCount_i;
    logic [3:0]  DownCount_i;
    logic [3:0]  ByteComp_i;
    logic        AcqSig_o;
    logic        BaudSig_o;
    logic        ByteSig_o;
    logic [3:0]  BitIdx_o;
    logic        Busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    baudrate_gen_comp dut (
        .clk         (clk),
        .rst         (rst),
        .Enable_i    (Enable_i),
        .Sync_i      (Sync_i),
        .AcqPeriod_i (AcqPeriod_i),
        .UpCount_i   (UpCount_i),
        .DownCount_i (DownCount_i),
        .ByteComp_i  (ByteComp_i),
        .AcqSig_o    (AcqSig_o),
        .BaudSig_o   (BaudSig_o),
        .ByteSig_o   (ByteSig_o),
        .BitIdx_o    (BitIdx_o),
        .Busy_o      (Busy_o)
    );

    task automatic cfg(input int n, input int u, input int d, input int c);
        AcqPeriod_i = 16'(n);
        UpCount_i   = 4'(u);
        DownCount_i = 4'(d);
        ByteComp_i  = 4'(c);
    endtask

    task automatic go_idle();
        Enable_i = 1'b0;
        Sync_i   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        repeat (2) @(negedge clk);
        obs = {AcqSig_o, BaudSig_o, ByteSig_o, Busy_o, BitIdx_o};
        n_checks++;
        if (obs !== 8'h00) $display("FAIL reset_outputs got=%h exp=00", obs);
        else n_pass++;
        @(negedge clk);
        obs = {AcqSig_o, BaudSig_o, ByteSig_o, Busy_o, BitIdx_o};
        n_checks++;
        if (obs !== 8'h00) $display("FAIL reset_hold got=%h exp=00", obs);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    // N=4 U=1 D=2: periods 4,4,5 -> 13-clock bit, pulses at offsets 4,8,13.
    task automatic test_basic();
        int p;
        logic ea, eb;
        logic [3:0] ei;
        go_idle();
        cfg(4, 1, 2, 0);
        Enable_i = 1'b1;
        for (int j = 0; j <= 40; j++) begin
            @(negedge clk);
            p  = j % 13;
            ea = (j > 0) && (p == 4 || p == 8 || p == 0);
            eb = (j > 0) && (p == 0);
            ei = (j == 0) ? 4'd0 : 4'((j - 1) / 13);
            if (j == 0) begin
                n_checks++;
                if (Busy_o !== 1'b1) $display("FAIL basic_busy got=%b exp=1", Busy_o);
                else n_pass++;
            end
            n_checks++;
            if (AcqSig_o !== ea) $display("FAIL basic_acq j=%0d got=%b exp=%b", j, AcqSig_o, ea);
            else n_pass++;
            n_checks++;
            if (BaudSig_o !== eb) $display("FAIL basic_baud j=%0d got=%b exp=%b", j, BaudSig_o, eb);
            else n_pass++;
            n_checks++;
            if (BitIdx_o !== ei) $display("FAIL basic_idx j=%0d got=%0d exp=%0d", j, BitIdx_o, ei);
            else n_pass++;
        end
    endtask

    // C=3: byte = 10*13+3 = 133 clocks; bit 9 periods 4,4,8 (ends at q=121,125,133).
    task automatic test_bytecomp();
        int q, r, t;
        logic ea, eb, ey;
        logic [3:0] ei;
        go_idle();
        cfg(4, 1, 2, 3);
        Enable_i = 1'b1;
        for (int j = 0; j <= 270; j++) begin
            @(negedge clk);
            q  = j % 133;
            r  = q % 13;
            ea = (j > 0) && (q == 0 || (q != 130 && (r == 4 || r == 8 || r == 0)));
            eb = (j > 0) && (q == 0 || (q != 130 && r == 0));
            ey = (j > 0) && (q == 0);
            t  = (q == 0) ? 9 : (q - 1) / 13;
            if (t > 9) t = 9;
            ei = (j == 0) ? 4'd0 : 4'(t);
            n_checks++;
            if (AcqSig_o !== ea) $display("FAIL comp_acq j=%0d got=%b exp=%b", j, AcqSig_o, ea);
            else n_pass++;
            n_checks++;
            if (BaudSig_o !== eb) $display("FAIL comp_baud j=%0d got=%b exp=%b", j, BaudSig_o, eb);
            else n_pass++;
            n_checks++;
            if (ByteSig_o !== ey) $display("FAIL comp_byte j=%0d got=%b exp=%b", j, ByteSig_o, ey);
            else n_pass++;
            n_checks++;
            if (BitIdx_o !== ei) $display("FAIL comp_idx j=%0d got=%0d exp=%0d", j, BitIdx_o, ei);
            else n_pass++;
        end
    endtask

    // N=1, U=D=0 clamp to N=2, D=1: one 2-clock period per bit.
    task automatic test_clamp();
        logic ea;
        logic [3:0] ei;
        go_idle();
        cfg(1, 0, 0, 0);
        Enable_i = 1'b1;
        for (int j = 0; j <= 24; j++) begin
            @(negedge clk);
            ea = (j > 0) && (j % 2 == 0);
            ei = (j == 0) ? 4'd0 : 4'(((j - 1) / 2) % 10);
            n_checks++;
            if (AcqSig_o !== ea) $display("FAIL clamp_acq j=%0d got=%b exp=%b", j, AcqSig_o, ea);
            else n_pass++;
            n_checks++;
            if (BaudSig_o !== ea) $display("FAIL clamp_baud j=%0d got=%b exp=%b", j, BaudSig_o, ea);
            else n_pass++;
            n_checks++;
            if (BitIdx_o !== ei) $display("FAIL clamp_idx j=%0d got=%0d exp=%0d", j, BitIdx_o, ei);
            else n_pass++;
        end
    endtask

    // N changes 4->6 at j=20; old 13-clock bits until byte end at 130, then 6,6,7.
    task automatic test_reconfig();
        int p;
        logic ea, eb, ey;
        go_idle();
        cfg(4, 1, 2, 0);
        Enable_i = 1'b1;
        for (int j = 0; j <= 170; j++) begin
            @(negedge clk);
            if (j <= 130) begin
                p  = j % 13;
                ea = (j > 0) && (p == 4 || p == 8 || p == 0);
                eb = (j > 0) && (p == 0);
            end else begin
                p  = (j - 130) % 19;
                ea = (p == 6 || p == 12 || p == 0);
                eb = (p == 0);
            end
            ey = (j == 130);
            n_checks++;
            if (AcqSig_o !== ea) $display("FAIL reconf_acq j=%0d got=%b exp=%b", j, AcqSig_o, ea);
            else n_pass++;
            n_checks++;
            if (BaudSig_o !== eb) $display("FAIL reconf_baud j=%0d got=%b exp=%b", j, BaudSig_o, eb);
            else n_pass++;
            n_checks++;
            if (ByteSig_o !== ey) $display("FAIL reconf_byte j=%0d got=%b exp=%b", j, ByteSig_o, ey);
            else n_pass++;
            if (j == 20) AcqPeriod_i = 16'd6;
        end
    endtask

    // Sync sampled on the edge that would have produced a pulse (j=73) in bit 5.
    task automatic test_sync();
        int p;
        logic ea, eb;
        go_idle();
        cfg(4, 1, 2, 0);
        Enable_i = 1'b1;
        for (int j = 0; j <= 72; j++) @(negedge clk);
        n_checks++;
        if (BitIdx_o !== 4'd5) $display("FAIL sync_pre_idx got=%0d exp=5", BitIdx_o);
        else n_pass++;
        Sync_i = 1'b1;
        for (int j = 73; j <= 87; j++) begin
            @(negedge clk);
            Sync_i = 1'b0;
            p  = j - 73;
            ea = (p == 4 || p == 8 || p == 13);
            eb = (p == 13);
            n_checks++;
            if (AcqSig_o !== ea) $display("FAIL sync_acq j=%0d got=%b exp=%b", j, AcqSig_o, ea);
            else n_pass++;
            n_checks++;
            if (BaudSig_o !== eb) $display("FAIL sync_baud j=%0d got=%b exp=%b", j, BaudSig_o, eb);
            else n_pass++;
            n_checks++;
            if (BitIdx_o !== ((p == 14) ? 4'd1 : 4'd0)) $display("FAIL sync_idx j=%0d got=%0d", j, BitIdx_o);
            else n_pass++;
        end
    endtask

    // Disable during period 2 of bit 1, sync in IDLE, async reset, fresh restart.
    task automatic test_disable_reset();
        logic [7:0] obs;
        go_idle();
        cfg(4, 1, 2, 0);
        Enable_i = 1'b1;
        for (int j = 0; j <= 19; j++) @(negedge clk);
        n_checks++;
        if (BitIdx_o !== 4'd1) $display("FAIL dis_pre_idx got=%0d exp=1", BitIdx_o);
        else n_pass++;
        Enable_i = 1'b0;
        for (int j = 20; j <= 40; j++) begin
            @(negedge clk);
            Sync_i = (j == 25);
            obs = {AcqSig_o, BaudSig_o, ByteSig_o, Busy_o, BitIdx_o};
            n_checks++;
            if (obs !== 8'h00) $display("FAIL dis_idle j=%0d got=%h exp=00", j, obs);
            else n_pass++;
        end
        Sync_i = 1'b0;
        rst = 1'b0;
        #1;
        obs = {AcqSig_o, BaudSig_o, ByteSig_o, Busy_o, BitIdx_o};
        n_checks++;
        if (obs !== 8'h00) $display("FAIL dis_rst got=%h exp=00", obs);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        // Asynchronous reset in the middle of bit 1.
        Enable_i = 1'b1;
        for (int j = 0; j <= 16; j++) @(negedge clk);
        n_checks++;
        if ({Busy_o, BitIdx_o} !== 5'b1_0001) $display("FAIL arst_pre got=%b exp=10001", {Busy_o, BitIdx_o});
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        obs = {AcqSig_o, BaudSig_o, ByteSig_o, Busy_o, BitIdx_o};
        n_checks++;
        if (obs !== 8'h00) $display("FAIL arst_immediate got=%h exp=00", obs);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (Busy_o !== 1'b0) $display("FAIL arst_hold got=%b exp=0", Busy_o);
        else n_pass++;
        rst = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            n_checks++;
            if (AcqSig_o !== (j == 4)) $display("FAIL restart_acq j=%0d got=%b exp=%b", j, AcqSig_o, (j == 4));
            else n_pass++;
            n_checks++;
            if ({Busy_o, BitIdx_o} !== 5'b1_0000) $display("FAIL restart_state j=%0d got=%b", j, {Busy_o, BitIdx_o});
            else n_pass++;
        end
    endtask

    initial begin
        rst      = 1'b0;
        Enable_i = 1'b0;
        Sync_i   = 1'b0;
        cfg(0, 0, 0, 0);
        test_reset();
        test_basic();
        test_bytecomp();
        test_clamp();
        test_reconfig();
        test_sync();
        test_disable_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
